// File: rtl/cluster_soc_evt_fifo.sv
// rtl/cluster_soc_evt_fifo.sv - SoC event FIFO ahead of the cluster event unit, with register slave
// Optional push/pop counters when SOC_EVT_FIFO_STATS_EN is defined.
module cluster_soc_evt_fifo #(
    parameter int EVNT_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int ID_WIDTH   = 9
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  soc_evt_valid_i,
    output logic                  soc_evt_ready_o,
    input  logic [EVNT_WIDTH-1:0] soc_evt_data_i,
    output logic                  cl_evt_valid_o,
    input  logic                  cl_evt_ready_i,
    output logic [EVNT_WIDTH-1:0] cl_evt_data_o,
    input  logic                  req_i,
    input  logic [31:0]           add_i,
    input  logic                  wen_i,
    input  logic [31:0]           wdata_i,
    input  logic [3:0]            be_i,
    input  logic [ID_WIDTH-1:0]   id_i,
    output logic                  gnt_o,
    output logic                  r_valid_o,
    output logic [31:0]           r_rdata_o,
    output logic                  r_opc_o,
    output logic [ID_WIDTH-1:0]   r_id_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [EVNT_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]           wptr_q, rptr_q, level;
    logic                  en_q, ovf_q;
    logic                  full, empty, push, pop;
    logic                  ctrl_wr, status_wr, flush;
    logic [1:0]            sel;
    logic [31:0]           status_w, rdata_d;
    logic                  opc_d;
    logic                  r_valid_q, r_opc_q;
    logic [31:0]           r_rdata_q;
    logic [ID_WIDTH-1:0]   r_id_q;
    logic                  unused_bits;

    assign unused_bits = ^{be_i, add_i[31:4], add_i[1:0], wdata_i[31:2]};

    assign level   = wptr_q - rptr_q;
    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign sel     = add_i[3:2];

    assign soc_evt_ready_o = !full;
    assign cl_evt_valid_o  = !empty && en_q;
    assign cl_evt_data_o   = mem_q[rptr_q[AW-1:0]];
    assign push            = soc_evt_valid_i && soc_evt_ready_o && !flush;
    assign pop             = cl_evt_valid_o && cl_evt_ready_i;

    assign gnt_o     = req_i;
    assign ctrl_wr   = req_i && !wen_i && (sel == 2'd0);
    assign status_wr = req_i && !wen_i && (sel == 2'd1);
    assign flush     = ctrl_wr && wdata_i[1];

    always_comb begin
        status_w       = '0;
        status_w[7:0]  = 8'(level);
        status_w[8]    = empty;
        status_w[9]    = full;
        status_w[10]   = ovf_q;
    end

`ifdef SOC_EVT_FIFO_STATS_EN
    logic [31:0] push_cnt_q, pop_cnt_q;

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            push_cnt_q <= '0;
            pop_cnt_q  <= '0;
        end else begin
            if (push) push_cnt_q <= push_cnt_q + 32'd1;
            if (pop)  pop_cnt_q  <= pop_cnt_q + 32'd1;
        end
    end
`endif

    always_comb begin
        rdata_d = '0;
        opc_d   = 1'b0;
        if (wen_i) begin
            case (sel)
                2'd0: rdata_d = {31'b0, en_q};
                2'd1: rdata_d = status_w;
`ifdef SOC_EVT_FIFO_STATS_EN
                2'd2: rdata_d = push_cnt_q;
                default: rdata_d = pop_cnt_q;
`else
                default: begin
                    rdata_d = 32'hDEADB33F;
                    opc_d   = 1'b1;
                end
`endif
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            en_q   <= 1'b1;
            ovf_q  <= 1'b0;
        end else begin
            if (push) mem_q[wptr_q[AW-1:0]] <= soc_evt_data_i;
            if (flush) begin
                wptr_q <= '0;
                rptr_q <= '0;
            end else begin
                if (push) wptr_q <= wptr_q + 1'b1;
                if (pop)  rptr_q <= rptr_q + 1'b1;
            end
            if (ctrl_wr) en_q <= wdata_i[0];
            // A blocked upstream event in the same cycle wins over the clear.
            if (soc_evt_valid_i && full) ovf_q <= 1'b1;
            else if (status_wr)          ovf_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid_q <= 1'b0;
            r_rdata_q <= '0;
            r_opc_q   <= 1'b0;
            r_id_q    <= '0;
        end else begin
            r_valid_q <= req_i;
            if (req_i) begin
                r_rdata_q <= rdata_d;
                r_opc_q   <= opc_d;
                r_id_q    <= id_i;
            end
        end
    end

    assign r_valid_o = r_valid_q;
    assign r_rdata_o = r_rdata_q;
    assign r_opc_o   = r_opc_q;
    assign r_id_o    = r_id_q;
endmodule
